// File: rtl/lane_engine_if.sv
// rtl/lane_engine_if.sv - control, press and display bundle between lane_engine and its neighbours
interface lane_engine_if #(
    parameter int LANES   = 4,
    parameter int DEPTH   = 100,
    parameter int SCORE_W = 10
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     step;
    logic                     running;
    logic [LANES*DEPTH-1:0]   pattern;
    logic [LANES-1:0]         press;
    logic [LANES*DEPTH-1:0]   lanes;
    logic [LANES-1:0]         head;
    logic [SCORE_W-1:0]       score;
    logic [LANES-1:0]         hit;
    logic [LANES-1:0]         miss;
    logic [CW-1:0]            step_count;
    logic                     done;

    modport master (
        output step, running, pattern, press,
        input  lanes, head, score, hit, miss, step_count, done
    );

    modport slave (
        input  step, running, pattern, press,
        output lanes, head, score, hit, miss, step_count, done
    );
endinterface

// File: rtl/lane_engine.sv
// rtl/lane_engine.sv - multi-lane note scroller and press scorer for the rhythm game
module lane_engine #(
    parameter int LANES     = 4,
    parameter int DEPTH     = 100,
    parameter int SCORE_W   = 10,
    parameter int MAX_SCORE = 999
) (
    input  logic          clk,
    input  logic          resetn,
    lane_engine_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    // Wide enough to hold score plus the largest per-cycle swing without overflow.
    localparam int SW = SCORE_W + 6;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_SCORE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state;
    logic [LANES*DEPTH-1:0]   lanes_q;
    logic [SCORE_W-1:0]       score_q;
    logic [LANES-1:0]         hit_q;
    logic [LANES-1:0]         miss_q;
    logic [CW-1:0]            count_q;
    logic                     done_q;
    logic [LANES-1:0]         judged;
    logic [LANES-1:0]         press_q;

    logic [LANES-1:0]         head_w;
    logic [LANES-1:0]         lane_edge;
    logic [LANES-1:0]         hit_n;
    logic [LANES-1:0]         miss_n;
    logic [LANES-1:0]         judged_n;
    logic [LANES*DEPTH-1:0]   shifted;
    logic signed [SW-1:0]     delta;
    logic signed [SW-1:0]     sum;
    logic [SCORE_W-1:0]       score_n;

    // Judge presses against the pre-shift head, flag passed notes, and form the clamped score.
    always_comb begin
        lane_edge = bus.press & ~press_q;
        hit_n     = '0;
        miss_n    = '0;
        judged_n  = judged;
        head_w    = '0;
        shifted   = '0;
        delta     = '0;
        for (int l = 0; l < LANES; l++) begin
            head_w[l] = lanes_q[l*DEPTH];
            shifted[l*DEPTH +: DEPTH] = {1'b0, lanes_q[l*DEPTH+1 +: DEPTH-1]};
            if (lane_edge[l] && !judged[l]) begin
                if (head_w[l]) begin
                    hit_n[l] = 1'b1;
                end else begin
                    miss_n[l] = 1'b1;
                end
                judged_n[l] = 1'b1;
            end
            // A lane already judged this step (including by a press this cycle) cannot also be a passed note.
            if (bus.step && head_w[l] && !judged_n[l]) begin
                miss_n[l] = 1'b1;
            end
            delta = delta + $signed({{(SW-1){1'b0}}, hit_n[l]})
                          - $signed({{(SW-1){1'b0}}, miss_n[l]});
        end
        sum = $signed({{(SW-SCORE_W){1'b0}}, score_q}) + delta;
        if (sum[SW-1]) begin
            score_n = '0;
        end else if (sum > MAX_S) begin
            score_n = SCORE_W'(MAX_SCORE);
        end else begin
            score_n = sum[SCORE_W-1:0];
        end
    end

    // Song-level state machine; hit/miss default low so they are single-cycle pulses.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state   <= S_IDLE;
            lanes_q <= '0;
            score_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            judged  <= '0;
            press_q <= '0;
        end else begin
            press_q <= bus.press;
            hit_q   <= '0;
            miss_q  <= '0;
            case (state)
                S_IDLE: begin
                    score_q <= '0;
                    count_q <= '0;
                    judged  <= '0;
                    done_q  <= 1'b0;
                    if (bus.running) begin
                        lanes_q <= bus.pattern;
                        state   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!bus.running) begin
                        state <= S_PAUSE;
                    end else begin
                        hit_q   <= hit_n;
                        miss_q  <= miss_n;
                        score_q <= score_n;
                        if (bus.step) begin
                            lanes_q <= shifted;
                            judged  <= '0;
                            count_q <= count_q + CW'(1);
                            if (count_q == CW'(DEPTH - 1)) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            judged <= judged_n;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.running) begin
                        state <= S_PLAY;
                    end
                end
                S_DONE: begin
                    if (!bus.running) begin
                        state   <= S_IDLE;
                        done_q  <= 1'b0;
                        score_q <= '0;
                        count_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.lanes      = lanes_q;
    assign bus.head       = head_w;
    assign bus.score      = score_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.step_count = count_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_lane_engine.sv
// tb/tb_lane_engine.sv - self-checking bench for lane_engine against a note-index reference model
module tb_lane_engine;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int DS = 520;
    localparam int MAXS = 999;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic resetn;

    lane_engine_if #(.LANES(L), .DEPTH(D),  .SCORE_W(10)) ia ();
    lane_engine_if #(.LANES(L), .DEPTH(DS), .SCORE_W(10)) sb ();

    lane_engine #(.LANES(L), .DEPTH(D), .SCORE_W(10), .MAX_SCORE(MAXS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ia)
    );

    lane_engine #(.LANES(L), .DEPTH(DS), .SCORE_W(10), .MAX_SCORE(MAXS)) dut_sat (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: each lane is the loaded song read from a moving index.
    int          m_mode;
    int          m_pos;
    int          m_pat [L][D];
    int          m_score;
    int          m_cnt;
    logic [L-1:0] m_judged;
    logic [L-1:0] m_prev;
    logic [L-1:0] e_hit;
    logic [L-1:0] e_miss;

    function automatic int m_head(input int l);
        return (m_pos < D) ? m_pat[l][m_pos] : 0;
    endfunction

    function automatic logic [L*D-1:0] e_lanes();
        logic [L*D-1:0] v;
        v = '0;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < D; i++)
                v[l*D+i] = (m_pos + i < D) ? m_pat[l][m_pos+i][0] : 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_pos    = D;
        m_score  = 0;
        m_cnt    = 0;
        m_judged = '0;
        m_prev   = '0;
        e_hit    = '0;
        e_miss   = '0;
    endtask

    task automatic model_step(input bit st, input bit run, input logic [L-1:0] pr);
        int net;
        e_hit  = '0;
        e_miss = '0;
        case (m_mode)
            M_IDLE: begin
                m_score = 0;
                m_cnt   = 0;
                if (run) begin
                    for (int l = 0; l < L; l++)
                        for (int i = 0; i < D; i++)
                            m_pat[l][i] = int'(ia.pattern[l*D+i]);
                    m_pos    = 0;
                    m_judged = '0;
                    m_mode   = M_PLAY;
                end
            end
            M_PLAY: begin
                if (!run) begin
                    m_mode = M_PAUSE;
                end else begin
                    net = 0;
                    for (int l = 0; l < L; l++) begin
                        if (pr[l] && !m_prev[l] && !m_judged[l]) begin
                            if (m_head(l) != 0) begin
                                e_hit[l] = 1'b1;
                                net++;
                            end else begin
                                e_miss[l] = 1'b1;
                                net--;
                            end
                            m_judged[l] = 1'b1;
                        end
                        if (st && m_head(l) != 0 && !m_judged[l]) begin
                            e_miss[l] = 1'b1;
                            net--;
                        end
                    end
                    m_score = m_score + net;
                    if (m_score < 0) m_score = 0;
                    if (m_score > MAXS) m_score = MAXS;
                    if (st) begin
                        m_pos++;
                        m_judged = '0;
                        m_cnt++;
                        if (m_cnt == D) m_mode = M_DONE;
                    end
                end
            end
            M_PAUSE: if (run) m_mode = M_PLAY;
            default: begin
                if (!run) begin
                    m_mode  = M_IDLE;
                    m_score = 0;
                    m_cnt   = 0;
                end
            end
        endcase
        m_prev = pr;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [L*D-1:0] el;
        logic [L-1:0]   eh;
        el = e_lanes();
        for (int l = 0; l < L; l++) eh[l] = el[l*D];
        check("lanes",      32'(ia.lanes),      32'(el));
        check("head",       32'(ia.head),       32'(eh));
        check("score",      32'(ia.score),      32'(m_score));
        check("hit",        32'(ia.hit),        32'(e_hit));
        check("miss",       32'(ia.miss),       32'(e_miss));
        check("step_count", 32'(ia.step_count), 32'(m_cnt));
        check("done",       32'(ia.done),       32'(m_mode == M_DONE));
        check("hit_and_miss_overlap", 32'(ia.hit & ia.miss), 32'd0);
    endtask

    task automatic tick(input bit st, input bit run, input logic [L-1:0] pr);
        ia.step    = st;
        ia.running = run;
        ia.press   = pr;
        model_step(st, run, pr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        ia.step    = 1'b0;
        ia.running = 1'b0;
        ia.press   = '0;
        resetn     = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        resetn = 1'b0;
    endtask

    initial begin
        resetn      = 1'b1;
        ia.step     = 1'b0;
        ia.running  = 1'b0;
        ia.press    = '0;
        ia.pattern  = '0;
        sb.step     = 1'b0;
        sb.running  = 1'b0;
        sb.press    = '0;
        sb.pattern  = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        resetn = 1'b0;

        // Single hit, then a second edge inside the same step is ignored.
        ia.pattern = 8'b0000_0001;
        tick(0, 1, 2'b00);
        check("load_lanes", 32'(ia.lanes), 32'h01);
        tick(0, 1, 2'b01);
        check("first_hit_score", 32'(ia.score), 32'd1);
        check("first_hit_pulse", 32'(ia.hit), 32'h1);
        tick(0, 1, 2'b00);
        tick(0, 1, 2'b01);
        check("second_edge_score", 32'(ia.score), 32'd1);
        check("second_edge_hit", 32'(ia.hit), 32'h0);
        tick(0, 1, 2'b00);
        for (int i = 0; i < D; i++) tick(1, 1, 2'b00);
        check("song_done", 32'(ia.done), 32'd1);
        tick(0, 0, 2'b00);

        // Wrong press at zero clamps; then a passed note.
        ia.pattern = 8'b0000_0010;
        tick(0, 1, 2'b00);
        tick(0, 1, 2'b01);
        check("wrong_press_miss", 32'(ia.miss), 32'h1);
        check("wrong_press_clamp", 32'(ia.score), 32'd0);
        tick(0, 1, 2'b00);
        tick(1, 1, 2'b00);
        check("head_after_step", 32'(ia.head), 32'h1);
        tick(1, 1, 2'b00);
        check("passed_note_miss", 32'(ia.miss), 32'h1);
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(0, 0, 2'b00);

        // Step and press on the same cycle.
        ia.pattern = 8'b0000_0101;
        tick(0, 1, 2'b00);
        tick(1, 1, 2'b01);
        check("step_press_hit", 32'(ia.hit), 32'h1);
        check("step_press_nomiss", 32'(ia.miss), 32'h0);
        check("step_press_lanes", 32'(ia.lanes), 32'h02);
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(0, 0, 2'b00);

        // Both lanes hit together, then pause and resume.
        ia.pattern = 8'b0001_0001;
        tick(0, 1, 2'b00);
        tick(0, 1, 2'b11);
        check("dual_hit", 32'(ia.hit), 32'h3);
        check("dual_hit_score", 32'(ia.score), 32'd2);
        tick(0, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(0, 0, 2'b00);
        tick(1, 0, 2'b00);
        tick(0, 0, 2'b01);
        check("pause_count_frozen", 32'(ia.step_count), 32'd1);
        tick(0, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        check("done_after_resume", 32'(ia.done), 32'd1);
        tick(0, 0, 2'b00);
        check("idle_score_zero", 32'(ia.score), 32'd0);

        // Asynchronous reset in the middle of a song.
        ia.pattern = 8'b1011_0111;
        tick(0, 1, 2'b00);
        tick(1, 1, 2'b10);
        tick(0, 1, 2'b01);
        async_reset();

        // Random play against the model.
        for (int c = 0; c < 400; c++) begin
            ia.pattern = 8'($urandom);
            tick(($urandom % 3) == 0, ($urandom % 8) != 0, 2'($urandom));
        end

        // Saturation on a deep pattern: +2 per step until the ceiling.
        sb.running = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 500; k++) begin
            sb.press = 2'b11;
            sb.step  = 1'b1;
            @(posedge clk);
            #1;
            check("sat_score", 32'(sb.score), 32'((2 * (k + 1) > MAXS) ? MAXS : 2 * (k + 1)));
            sb.press = 2'b00;
            sb.step  = 1'b0;
            @(posedge clk);
            #1;
        end
        sb.press = 2'b11;
        @(posedge clk);
        #1;
        check("sat_hit_pulse", 32'(sb.hit), 32'h3);
        check("sat_hold", 32'(sb.score), 32'(MAXS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lane_engine.md
# lane_engine

Multi-lane note engine for the rhythm game: holds one scrolling note pattern per lane, advances all lanes on a step tick from the rate divider, and scores player presses against the note at each lane head. It sits between the rate divider/input synchronisers and the VGA renderer/score display. It generalises the single-lane game datapath with these additions:
- configurable lane count and pattern depth
- per-press edge detection
- one-judgement-per-step locking
- missed-note penalties
- saturating score arithmetic
- pause, and end-of-song detection

## Interface
Parameters:
- LANES, 4, number of lanes (1..8)
- DEPTH, 100, notes per lane pattern (>=2)
- SCORE_W, 10, score width
- MAX_SCORE, 999, saturation ceiling (< 2**SCORE_W)

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  reset, asynchronous, active-high
- step  in  1  one-cycle scroll tick from rate divider
- running  in  1  play enable (level, pre-synchronised)
- pattern  in  LANES*DEPTH  song; lane L occupies bits [L*DEPTH +: DEPTH], bit 0 = first note to reach head
- press  in  LANES  lane buttons, active-high level, pre-synchronised
- lanes  out  LANES*DEPTH  current lane contents for renderer
- head  out  LANES  bit 0 of each lane
- score  out  SCORE_W  current score
- hit  out  LANES  one-cycle pulse per correct press
- miss  out  LANES  one-cycle pulse per wrong press or passed note
- step_count  out  $clog2(DEPTH+1)  steps taken this song
- done  out  1  song finished

## Operation
- Reset: state IDLE. lanes, score, hit, miss, step_count, done, per-lane judged flags and press_q are all cleared to 0.
- IDLE: score and step_count are held at 0. If running=1, load pattern into lanes and go to PLAY on the next edge.
- PLAY, press handling:
  - A rising edge in lane L is `press[L] & ~press_q[L]`; press_q is registered every cycle in every state.
  - Edge, judged[L]=0, head[L]=1: hit[L] pulses, +1 to score, judged[L] set.
  - Edge, judged[L]=0, head[L]=0: miss[L] pulses, -1 to score, judged[L] set.
  - Edge with judged[L]=1: ignored, with no pulse.
- PLAY, step=1:
  - For each lane with head=1 and judged=0, assert miss[L] (passed note, -1).
  - Shift every lane right by 1, filling with 0.
  - Clear all judged flags and increment step_count.
- Step and press on the same cycle: the press is judged against the pre-shift head and sets judged, so the passed-note check for that lane is suppressed. The shift still occurs and judged is then cleared.
- Score arithmetic:
  - Net delta per cycle = (#hits) - (#misses) across all lanes.
  - Apply as a signed sum, clamped to [0, MAX_SCORE]; there is no wrap in either direction.
- PLAY -> PAUSE when running=0. In PAUSE, step and press edges are ignored, and lanes, judged and score are held. PAUSE -> PLAY when running=1.
- PLAY -> DONE on the step that makes step_count == DEPTH; that step is processed normally first. DONE holds done=1 and all other state. DONE -> IDLE when running=0.
- Asynchronous reset in any state returns to IDLE immediately. A partially played song is discarded.

## Timing
- All outputs are registered.
- Latency, edge to edge:
  - press rise sampled at edge N: hit/miss and the updated score are visible after edge N.
  - step sampled at edge N: shifted lanes/head, step_count, and the passed-note miss are visible after edge N.
- IDLE -> PLAY takes 1 cycle, and lanes are valid in the same cycle PLAY is entered.
- hit/miss are exactly one cycle wide and are never asserted together on the same lane in the same cycle.
- A press held high across steps generates no further judgements. A new edge is required.

## Test plan
- LANES=2, DEPTH=4, lane0=4'b0001: run, press lane0 once before any step -> hit[0] one cycle, score 0->1. Second press edge in the same step -> no pulse, score stays 1.
- lane0=4'b0010: press lane0 before step -> miss[0], score clamps at 0. Step -> head[0]=1. No press, next step -> miss[0] pulse for passed note, score stays 0.
- step and press edge asserted in the same cycle with head[0]=1 -> hit[0] only, no passed-note miss, lanes shifted, score +1.
- Both lanes head=1, press both simultaneously -> hit=2'b11, score +2 in one cycle. Preload score near MAX_SCORE (run hits to 999 at SCORE_W=10) -> further hits keep score at 999.
- Drop running mid-song -> PAUSE; steps/presses ignored, step_count frozen. Raise running -> resumes. After 4 steps done=1. Drop running -> IDLE, score 0.
- Assert resetn for 1 cycle mid-PLAY, asynchronously between clock edges -> all outputs 0 immediately, state IDLE.
